keyboard_lane_tracker: RTL
==========================

// Module: keyboard_lane_tracker
// PURPOSE
//  Parametrised successor to the fixed F/G/H/J key decode. Watches NUM_LANES configurable
//  scan codes in the 512-bit key_down vector from the PS/2 keyboard decoder. Each lane is
//  debounced independently and produces one-cycle press, release and long-hold pulses plus
//  a saturating hold counter. Sits between the keyboard decoder and the game note-judging
//  logic.
// PARAMETERS
//  NUM_LANES    4                      number of tracked lanes, 1..16
//  LANE_CODES   {9'h3B,9'h33,9'h34,9'h2B}  packed 9-bit codes, lane i = bits [9i+8:9i] (default F,G,H,J)
//  DEBOUNCE_CYC 3                      consecutive stable samples needed to change state, >=1
//  HOLD_W       16                     width of each hold counter
//  LONG_CYC     1000                   hold_cnt value that fires lane_long, 1..2^HOLD_W-1
// PORTS
//  clk            in   1              system clock
//  rst_n          in   1              asynchronous reset, active low
//  en             in   1              lane tracking enable
//  key_down       in   512            level key-state vector from keyboard decoder
//  lane_held      out  NUM_LANES      debounced held level per lane
//  lane_press     out  NUM_LANES      1-cycle pulse on debounced press
//  lane_release   out  NUM_LANES      1-cycle pulse on debounced release
//  lane_long      out  NUM_LANES      1-cycle pulse when hold_cnt reaches LONG_CYC
//  lane_hold_cnt  out  NUM_LANES*HOLD_W  cycles held per lane, lane i = [HOLD_W*i +: HOLD_W]
//  any_press      out  1              OR of lane_press
//  first_lane     out  4              lowest lane index pulsing lane_press this cycle; 0 if none
// BEHAVIOUR
//  Reset: all outputs 0, all lane FSMs IDLE, all counters 0.
//  Input stage: key_q[i] <= key_down[LANE_CODES[i]] every edge. The FSM uses key_q only,
//  which adds 1 cycle of latency.
//  Per-lane FSM with debounce counter deb (width clog2(DEBOUNCE_CYC+1)):
//   IDLE   : key_q=1 -> DEB_DN with deb=1. Otherwise stay.
//   DEB_DN : key_q=0 -> IDLE and deb=0.
//            key_q=1 and deb==DEBOUNCE_CYC -> HELD; lane_press=1 for that single cycle;
//            hold_cnt=0. Otherwise deb++.
//   HELD   : key_q=0 -> DEB_UP with deb=1. Otherwise hold_cnt++.
//   DEB_UP : key_q=1 -> HELD and deb=0; this is a bounce, so no pulse fires.
//            key_q=0 and deb==DEBOUNCE_CYC -> IDLE; lane_release=1 for that single cycle.
//            Otherwise deb++.
//            hold_cnt keeps incrementing while in DEB_UP.
//  lane_held=1 in HELD and DEB_UP.
//  Latency: key_down bit rises and stays high before edge E0. lane_press is high in the
//  cycle after edge E0+DEBOUNCE_CYC+1. Release timing is symmetric.
//  hold_cnt: saturates at all-ones and never wraps. It keeps its value after release
//  until the next press clears it.
//  lane_long: fires on the edge where hold_cnt becomes LONG_CYC. It fires at most once per
//  press, even while saturated.
//  Lanes are fully independent: simultaneous presses on several lanes all pulse in the
//  same cycle.
//  first_lane: lowest-index priority encoder over lane_press.
//  Duplicate codes in LANE_CODES are legal; those lanes behave identically.
//  en=0: on the next edge every FSM goes to IDLE and deb and hold_cnt clear. No release
//  pulse is emitted for lanes that were held. key_q keeps sampling.
//  en rising: a key already held is treated as a fresh press once DEBOUNCE_CYC is met.
//  rst_n low mid-press: the block returns to reset values immediately, with no pulses.
//  All pulse outputs are registered and are 0 whenever no transition occurs.
// TESTING
//  1 DEBOUNCE_CYC=3. Raise key_down[9'h2B] before edge 0 and hold it.
//    -> lane_press[0] high only in the cycle after edge 4; lane_held[0]=1 from then on;
//       any_press=1; first_lane=0.
//  2 Bounce: key_down[9'h34] high for 2 cycles, low for 1, then high steadily.
//    -> no pulse during the glitch; a single lane_press[1] fires 4 cycles after the
//       steady rise.
//  3 Hold lane 3 (9'h3B) with LONG_CYC=10.
//    -> lane_long[3] fires once, when hold_cnt=10.
//    -> with HOLD_W=4, hold_cnt saturates at 15 and lane_long does not fire again.
//  4 Press F and J in the same cycle.
//    -> lane_press=4'b1001 in one cycle; first_lane=0.
//    -> release J only: lane_release=4'b1000 after the debounce delay.
//  5 Hold H and drop en for 1 cycle.
//    -> lane_held[2]=0, no lane_release pulse, hold_cnt=0.
//    -> after en returns, a new lane_press[2] fires 4 cycles later.
//  6 Assert rst_n=0 asynchronously while G is in DEB_DN.
//    -> all outputs are 0 at once, and no pulse appears after reset releases unless the key
//       is sampled again.

Source files
------------

// File: rtl/keyboard_lane_tracker.sv
// Tracks NUM_LANES configurable scan codes from the 512-bit key_down vector,
// debouncing each lane and emitting press/release/long-hold pulses plus hold counters.
module keyboard_lane_tracker #(
    parameter int                     NUM_LANES    = 4,
    parameter logic [9*NUM_LANES-1:0] LANE_CODES   = {9'h3B, 9'h33, 9'h34, 9'h2B},
    parameter int                     DEBOUNCE_CYC = 3,
    parameter int                     HOLD_W       = 16,
    parameter int                     LONG_CYC     = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [511:0]                key_down,
    output logic [NUM_LANES-1:0]        lane_held,
    output logic [NUM_LANES-1:0]        lane_press,
    output logic [NUM_LANES-1:0]        lane_release,
    output logic [NUM_LANES-1:0]        lane_long,
    output logic [NUM_LANES*HOLD_W-1:0] lane_hold_cnt,
    output logic                        any_press,
    output logic [3:0]                  first_lane
);

    localparam int DEB_W = (DEBOUNCE_CYC + 1 > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEB_DN = 2'd1,
        HELD   = 2'd2,
        DEB_UP = 2'd3
    } lane_state_t;

    // Per-lane state is kept as arrays so it can be probed hierarchically.
    lane_state_t          state_q  [NUM_LANES];
    logic [DEB_W-1:0]     deb_q    [NUM_LANES];
    logic [HOLD_W-1:0]    hold_q   [NUM_LANES];
    logic [HOLD_W-1:0]    hold_inc [NUM_LANES];
    logic [NUM_LANES-1:0] long_hit;
    logic [NUM_LANES-1:0] key_q;
    logic [NUM_LANES-1:0] press_q;
    logic [NUM_LANES-1:0] release_q;
    logic [NUM_LANES-1:0] long_q;
    logic                 unused_keys;

    assign unused_keys = ^key_down;

    // Saturating increment; long_hit marks the step that lands exactly on LONG_CYC.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            hold_inc[i] = (&hold_q[i]) ? hold_q[i] : hold_q[i] + HOLD_W'(1);
            long_hit[i] = (hold_q[i] == HOLD_W'(LONG_CYC - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                state_q[i] <= IDLE;
                deb_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
        end else begin
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                key_q[i] <= key_down[LANE_CODES[9*i +: 9]];
            end
            if (!en) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    state_q[i] <= IDLE;
                    deb_q[i]   <= '0;
                    hold_q[i]  <= '0;
                end
            end else begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    case (state_q[i])
                        IDLE: begin
                            if (key_q[i]) begin
                                state_q[i] <= DEB_DN;
                                deb_q[i]   <= DEB_W'(1);
                            end
                        end
                        DEB_DN: begin
                            if (!key_q[i]) begin
                                state_q[i] <= IDLE;
                                deb_q[i]   <= '0;
                            end else if (deb_q[i] == DEB_W'(DEBOUNCE_CYC)) begin
                                state_q[i] <= HELD;
                                deb_q[i]   <= '0;
                                hold_q[i]  <= '0;
                                press_q[i] <= 1'b1;
                            end else begin
                                deb_q[i] <= deb_q[i] + DEB_W'(1);
                            end
                        end
                        HELD: begin
                            if (!key_q[i]) begin
                                state_q[i] <= DEB_UP;
                                deb_q[i]   <= DEB_W'(1);
                            end else begin
                                hold_q[i] <= hold_inc[i];
                                long_q[i] <= long_hit[i];
                            end
                        end
                        DEB_UP: begin
                            // The hold counter keeps running while a release is pending.
                            hold_q[i] <= hold_inc[i];
                            long_q[i] <= long_hit[i];
                            if (key_q[i]) begin
                                state_q[i] <= HELD;
                                deb_q[i]   <= '0;
                            end else if (deb_q[i] == DEB_W'(DEBOUNCE_CYC)) begin
                                state_q[i]   <= IDLE;
                                deb_q[i]     <= '0;
                                release_q[i] <= 1'b1;
                            end else begin
                                deb_q[i] <= deb_q[i] + DEB_W'(1);
                            end
                        end
                        default: begin
                            state_q[i] <= IDLE;
                            deb_q[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        lane_held     = '0;
        lane_hold_cnt = '0;
        first_lane    = 4'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_held[i]                     = (state_q[i] == HELD) || (state_q[i] == DEB_UP);
            lane_hold_cnt[HOLD_W*i +: HOLD_W] = hold_q[i];
        end
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (press_q[i]) first_lane = 4'(i);
        end
    end

    assign lane_press   = press_q;
    assign lane_release = release_q;
    assign lane_long    = long_q;
    assign any_press    = |press_q;

endmodule
